// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline types, forward encodings and match helper
package hazard_ctrl_pkg;

  // Register-index width of the integer register file
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [1:0]       fwd_sel_t;

  // Operand-select encodings; 2'b11 is never produced
  localparam fwd_sel_t FWD_RF  = 2'b00;  // value read from the register file
  localparam fwd_sel_t FWD_ALU = 2'b01;  // ALU result held in stage 3
  localparam fwd_sel_t FWD_WB  = 2'b10;  // write-back data in stage 4

  // Shadow of the ID/EX register (stage 2)
  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     reg_wr;
    logic     mem_rd;
  } shadow_s2_t;

  // Shadow of the EX/MEM register (stage 3)
  typedef struct packed {
    reg_idx_t rd;
    logic     reg_wr;
    logic     mem_rd;
  } shadow_s3_t;

  // Shadow of the MEM/WB register (stage 4)
  typedef struct packed {
    reg_idx_t rd;
    logic     reg_wr;
  } shadow_s4_t;

  // A producer matches a source only if it writes a real register (x0 is hardwired zero)
  function automatic logic reg_match(input reg_idx_t rd, input logic reg_wr, input reg_idx_t src);
    return reg_wr && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - per-operand forward select with stage-3 priority over stage-4
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_rd_s3,
  input  logic             i_reg_wr_s3,
  input  logic [REG_W-1:0] i_rd_s4,
  input  logic             i_reg_wr_s4,
  output logic [1:0]       o_sel
);

  // Youngest producer wins so the most recent value of the register is used
  always_comb begin
    o_sel = FWD_RF;
    if (reg_match(i_rd_s3, i_reg_wr_s3, i_src)) begin
      o_sel = FWD_ALU;
    end else if (reg_match(i_rd_s4, i_reg_wr_s4, i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use/branch stall and flush control for a 5-stage pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_s1,
  input  logic [REG_W-1:0] rs2_s1,
  input  logic             use_rs1_s1,
  input  logic             use_rs2_s1,
  input  logic             branch_s1,
  input  logic [REG_W-1:0] rd_s1,
  input  logic             reg_wr_s1,
  input  logic             mem_rd_s1,
  input  logic             br_taken_s1,
  output logic [1:0]       forward_A,
  output logic [1:0]       forward_B,
  output logic [1:0]       forward_C,
  output logic [1:0]       forward_D,
  output logic             stall_if,
  output logic             bubble_s2,
  output logic             flush_s1,
  output logic [31:0]      stall_cnt
);

  shadow_s2_t  r_s2;
  shadow_s3_t  r_s3;
  shadow_s4_t  r_s4;
  logic [31:0] r_stall_cnt;

  logic        w_s2_hit;
  logic        w_s3_hit;
  logic        w_load_use;
  logic        w_br_haz;
  logic        w_stall;
  logic        w_s3_alu_wr;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic [1:0]  w_fwd_c;
  logic [1:0]  w_fwd_d;

  // Detect which older stages produce a register the decode instruction actually reads
  always_comb begin
    w_s2_hit = (use_rs1_s1 && reg_match(r_s2.rd, r_s2.reg_wr, rs1_s1)) ||
               (use_rs2_s1 && reg_match(r_s2.rd, r_s2.reg_wr, rs2_s1));
    w_s3_hit = (use_rs1_s1 && reg_match(r_s3.rd, r_s3.reg_wr, rs1_s1)) ||
               (use_rs2_s1 && reg_match(r_s3.rd, r_s3.reg_wr, rs2_s1));
    // A load in EX has no data yet for an ALU consumer; a branch compared in decode
    // additionally cannot take an ALU result still in EX nor a load still in MEM
    w_load_use = r_s2.mem_rd && w_s2_hit;
    w_br_haz   = branch_s1 && (w_s2_hit || (r_s3.mem_rd && w_s3_hit));
    w_stall    = w_load_use || w_br_haz;
    // Load data in stage 3 is not ready for the decode-stage comparator
    w_s3_alu_wr = r_s3.reg_wr && !r_s3.mem_rd;
  end

  hazard_fwd_sel u_fwd_a (
    .i_src       (r_s2.rs1),
    .i_rd_s3     (r_s3.rd),
    .i_reg_wr_s3 (r_s3.reg_wr),
    .i_rd_s4     (r_s4.rd),
    .i_reg_wr_s4 (r_s4.reg_wr),
    .o_sel       (w_fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .i_src       (r_s2.rs2),
    .i_rd_s3     (r_s3.rd),
    .i_reg_wr_s3 (r_s3.reg_wr),
    .i_rd_s4     (r_s4.rd),
    .i_reg_wr_s4 (r_s4.reg_wr),
    .o_sel       (w_fwd_b)
  );

  hazard_fwd_sel u_fwd_c (
    .i_src       (rs1_s1),
    .i_rd_s3     (r_s3.rd),
    .i_reg_wr_s3 (w_s3_alu_wr),
    .i_rd_s4     (r_s4.rd),
    .i_reg_wr_s4 (r_s4.reg_wr),
    .o_sel       (w_fwd_c)
  );

  hazard_fwd_sel u_fwd_d (
    .i_src       (rs2_s1),
    .i_rd_s3     (r_s3.rd),
    .i_reg_wr_s3 (w_s3_alu_wr),
    .i_rd_s4     (r_s4.rd),
    .i_reg_wr_s4 (r_s4.reg_wr),
    .o_sel       (w_fwd_d)
  );

  // Advance the shadow pipeline; a stalled decode instruction leaves a bubble behind it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2 <= '0;
      r_s3 <= '0;
      r_s4 <= '0;
    end else begin
      r_s4.rd     <= r_s3.rd;
      r_s4.reg_wr <= r_s3.reg_wr;
      r_s3.rd     <= r_s2.rd;
      r_s3.reg_wr <= r_s2.reg_wr;
      r_s3.mem_rd <= r_s2.mem_rd;
      if (w_stall) begin
        // A bubble carries no operands, so it can neither forward nor match
        r_s2 <= '0;
      end else begin
        r_s2.rs1    <= rs1_s1;
        r_s2.rs2    <= rs2_s1;
        r_s2.rd     <= rd_s1;
        r_s2.reg_wr <= reg_wr_s1;
        r_s2.mem_rd <= mem_rd_s1;
      end
    end
  end

  // Count stalled cycles, sticking at the maximum instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Outputs are forced quiet while reset is held so a stall in flight is dropped at once
  always_comb begin
    forward_A = rst_n ? w_fwd_a : FWD_RF;
    forward_B = rst_n ? w_fwd_b : FWD_RF;
    forward_C = (rst_n && branch_s1) ? w_fwd_c : FWD_RF;
    forward_D = (rst_n && branch_s1) ? w_fwd_d : FWD_RF;
    stall_if  = rst_n && w_stall;
    bubble_s2 = rst_n && w_stall;
    flush_s1  = rst_n && br_taken_s1 && branch_s1 && !w_stall;
    stall_cnt = r_stall_cnt;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] A = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_s1, rs2_s1, rd_s1;
  logic        use_rs1_s1, use_rs2_s1, branch_s1, reg_wr_s1, mem_rd_s1, br_taken_s1;
  logic [1:0]  forward_A, forward_B, forward_C, forward_D;
  logic        stall_if, bubble_s2, flush_s1;
  logic [31:0] stall_cnt;

  hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_s1      (rs1_s1),
    .rs2_s1      (rs2_s1),
    .use_rs1_s1  (use_rs1_s1),
    .use_rs2_s1  (use_rs2_s1),
    .branch_s1   (branch_s1),
    .rd_s1       (rd_s1),
    .reg_wr_s1   (reg_wr_s1),
    .mem_rd_s1   (mem_rd_s1),
    .br_taken_s1 (br_taken_s1),
    .forward_A   (forward_A),
    .forward_B   (forward_B),
    .forward_C   (forward_C),
    .forward_D   (forward_D),
    .stall_if    (stall_if),
    .bubble_s2   (bubble_s2),
    .flush_s1    (flush_s1),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2, br;
    logic [4:0] rd;
    logic       wr, mrd, bt;
    logic [1:0] fa, fb, fc, fd;
    logic       st, fl;
  } vec_t;

  typedef struct {
    logic [1:0]  fa, fb, fc, fd;
    logic        st, bub, fl;
    logic [31:0] cnt;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          vec_idx = 0;
  logic [31:0] model_cnt = 32'd0;

  function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic br,
                              input logic [4:0] rd, input logic wr, input logic mrd, input logic bt,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [1:0] fc, input logic [1:0] fd,
                              input logic st, input logic fl);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.br = br;
    v.rd = rd; v.wr = wr; v.mrd = mrd; v.bt = bt;
    v.fa = fa; v.fb = fb; v.fc = fc; v.fd = fd; v.st = st; v.fl = fl;
    return v;
  endfunction

  // NOP in decode with expected EX-stage selects
  function automatic vec_t nx(input logic [1:0] fa, input logic [1:0] fb);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb, R, R, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int idx);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  // One cycle: drive decode inputs, queue the expectation, compare on the falling edge
  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = v.rst; rs1_s1 = v.rs1; rs2_s1 = v.rs2; use_rs1_s1 = v.u1; use_rs2_s1 = v.u2;
    branch_s1 = v.br; rd_s1 = v.rd; reg_wr_s1 = v.wr; mem_rd_s1 = v.mrd; br_taken_s1 = v.bt;
    e.fa = v.fa; e.fb = v.fb; e.fc = v.fc; e.fd = v.fd;
    e.st = v.st; e.bub = v.st; e.fl = v.fl; e.cnt = model_cnt;
    sb_q.push_back(e);
    if (!v.rst) model_cnt = 32'd0;
    else if (v.st) model_cnt = model_cnt + 32'd1;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard vec %0d: got empty queue expected one entry", vec_idx);
    end else begin
      e = sb_q.pop_front();
      chk("forward_A", {30'd0, forward_A}, {30'd0, e.fa}, vec_idx);
      chk("forward_B", {30'd0, forward_B}, {30'd0, e.fb}, vec_idx);
      chk("forward_C", {30'd0, forward_C}, {30'd0, e.fc}, vec_idx);
      chk("forward_D", {30'd0, forward_D}, {30'd0, e.fd}, vec_idx);
      chk("stall_if", {31'd0, stall_if}, {31'd0, e.st}, vec_idx);
      chk("bubble_s2", {31'd0, bubble_s2}, {31'd0, e.bub}, vec_idx);
      chk("flush_s1", {31'd0, flush_s1}, {31'd0, e.fl}, vec_idx);
      chk("stall_cnt", stall_cnt, e.cnt, vec_idx);
    end
    vec_idx++;
  endtask

  // lw x7 -> beq x7 with reset asserted in the second stall cycle
  task automatic reset_mid_stall();
    step(mk(1, 1, 0, 1, 0, 0, 7, 1, 1, 0, R, R, R, R, 0, 0));
    step(mk(1, 7, 3, 1, 1, 1, 0, 0, 0, 1, R, R, R, R, 1, 0));
    step(mk(0, 7, 3, 1, 1, 1, 0, 0, 0, 1, R, R, R, R, 0, 0));
    step(nx(R, R));
    step(mk(1, 7, 3, 1, 1, 1, 0, 0, 0, 0, R, R, R, R, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rs1_s1 = '0; rs2_s1 = '0; rd_s1 = '0;
    use_rs1_s1 = 1'b0; use_rs2_s1 = 1'b0; branch_s1 = 1'b0;
    reg_wr_s1 = 1'b0; mem_rd_s1 = 1'b0; br_taken_s1 = 1'b0;

    // Held in reset with a busy-looking decode instruction: outputs stay quiet
    vecs.push_back(mk(0, 5, 6, 1, 1, 1, 7, 1, 1, 1, R, R, R, R, 0, 0));
    // add x5 ; sub rs1=x5 -> ALU forward
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 5, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(mk(1, 5, 3, 1, 1, 0, 8, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(nx(A, R));
    // add x5 ; nop ; sub rs1=x5 -> write-back forward
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 5, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(nx(R, R));
    vecs.push_back(mk(1, 5, 3, 1, 1, 0, 8, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(nx(W, R));
    vecs.push_back(nx(R, R));
    vecs.push_back(nx(R, R));
    // two writers of x5 back to back: stage 3 wins on both operands
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 5, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 5, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(mk(1, 5, 5, 1, 1, 0, 8, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(nx(A, A));
    vecs.push_back(nx(R, R));
    vecs.push_back(nx(R, R));
    // lw x6 ; add rs2=x6 -> one stall then write-back forward
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 6, 1, 1, 0, R, R, R, R, 0, 0));
    vecs.push_back(mk(1, 2, 6, 1, 1, 0, 9, 1, 0, 0, R, R, R, R, 1, 0));
    vecs.push_back(mk(1, 2, 6, 1, 1, 0, 9, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(nx(R, W));
    vecs.push_back(nx(R, R));
    vecs.push_back(nx(R, R));
    // lw x7 ; taken beq x7 -> two stalls, no flush until the stall clears
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 7, 1, 1, 0, R, R, R, R, 0, 0));
    vecs.push_back(mk(1, 7, 3, 1, 1, 1, 0, 0, 0, 1, R, R, R, R, 1, 0));
    vecs.push_back(mk(1, 7, 3, 1, 1, 1, 0, 0, 0, 1, R, R, R, R, 1, 0));
    vecs.push_back(mk(1, 7, 3, 1, 1, 1, 0, 0, 0, 1, R, R, W, R, 0, 1));
    vecs.push_back(nx(R, R));
    vecs.push_back(nx(R, R));
    // addi x7 ; untaken beq x7 -> one stall then ALU forward to the comparator
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 7, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(mk(1, 7, 3, 1, 1, 1, 0, 0, 0, 0, R, R, R, R, 1, 0));
    vecs.push_back(mk(1, 7, 3, 1, 1, 1, 0, 0, 0, 0, R, R, A, R, 0, 0));
    vecs.push_back(nx(W, R));
    vecs.push_back(nx(R, R));
    vecs.push_back(nx(R, R));
    // writes to x0 (ALU and load) never forward or stall
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 4, 1, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(mk(1, 2, 0, 1, 0, 0, 0, 1, 1, 0, R, R, R, R, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, R, R, R, R, 0, 0));
    vecs.push_back(nx(R, R));
    vecs.push_back(nx(R, R));
    // taken beq with no hazard -> single-cycle flush
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 1, R, R, R, R, 0, 1));
    vecs.push_back(nx(R, R));
    vecs.push_back(nx(R, R));

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    reset_mid_stall();

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have no parameters; register-index width is fixed at 5 and data width is not used.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 rs1_s1, rs2_s1  input  5 each  decode-stage source register indices.
REQ-005 use_rs1_s1, use_rs2_s1  input  1 each  decode instruction reads rs1/rs2.
REQ-006 branch_s1  input  1  decode instruction is a branch compared in decode (consumes forward_C/D).
REQ-007 rd_s1, reg_wr_s1, mem_rd_s1  input  5,1,1  decode-stage destination, register-write enable, load flag.
REQ-008 br_taken_s1  input  1  decode branch comparator result.
REQ-009 forward_A, forward_B  output  2 each  EX-stage ALU operand selects.
REQ-010 forward_C, forward_D  output  2 each  decode-stage branch operand selects.
REQ-011 stall_if  output  1  hold PC and IF/ID register.
REQ-012 bubble_s2  output  1  load NOP into ID/EX register.
REQ-013 flush_s1  output  1  clear IF/ID register (taken branch).
REQ-014 stall_cnt  output  32  count of cycles with stall_if high, saturating.

Function
REQ-015 Select encoding SHALL be 00 register file, 01 AluOut (result registered in s3), 10 RegWdata_s4; 11 never driven.
REQ-016 The module SHALL keep shadow pipeline registers {rs1,rs2,rd,reg_wr,mem_rd} for s2, {rd,reg_wr,mem_rd} for s3 and {rd,reg_wr} for s4, advancing s1->s2->s3->s4 every cycle.
REQ-017 When bubble_s2 is high, s2 shadow SHALL load reg_wr=0, mem_rd=0, rd=0 instead of s1 values; s3/s4 always advance.
REQ-018 A match SHALL require reg_wr=1, rd!=0 and rd equal to the source index; x0 never forwards or stalls.
REQ-019 forward_A/B SHALL be 01 on s3 match, else 10 on s4 match, else 00 (s3 has priority), combinational from shadow state.
REQ-020 forward_C/D SHALL be 01 on s3 match with mem_rd_s3=0, else 10 on s4 match, else 00; evaluated only when branch_s1=1, otherwise 00.
REQ-021 Load-use hazard: mem_rd_s2=1 and s2 matches a used s1 source -> stall.
REQ-022 Branch hazard: branch_s1=1 and (s2 matches a used source, or s3 matches with mem_rd_s3=1) -> stall.
REQ-023 On stall: stall_if=1, bubble_s2=1, flush_s1=0; dependency SHALL be re-evaluated each cycle, giving 1 stall cycle for ALU->branch and load->ALU, 2 for load->branch.
REQ-024 flush_s1 SHALL equal br_taken_s1 AND branch_s1 AND NOT stall; stall wins when both occur.
REQ-025 forward_A/B SHALL never select 01 while mem_rd_s3=1 for the matching source; the load-use stall guarantees it.
REQ-026 stall_cnt SHALL increment by 1 on each cycle with stall_if=1 and hold at 32'hFFFF_FFFF.

Reset
REQ-027 With rst_n=0 at a rising edge, all shadow reg_wr/mem_rd SHALL clear, rd/rs fields SHALL clear to 0 and stall_cnt SHALL clear to 0.
REQ-028 During and immediately after reset, forward_A..D SHALL be 00 and stall_if, bubble_s2, flush_s1 SHALL be 0; reset mid-stall SHALL abandon the stall.

Structure
REQ-029 Forward encodings (FWD_RF, FWD_ALU, FWD_WB) and the register-index width SHALL live in a shared pipeline package.
REQ-030 A combinational sub-module hazard_fwd_sel (source index plus s3/s4 rd/reg_wr in, 2-bit select out) SHALL be instantiated four times.

Verification
REQ-031 Sequence add x5 then sub uses x5 as rs1 -> forward_A=01 in sub's EX cycle; with one NOP between them -> forward_A=10.
REQ-032 Sequence lw x6 then add uses x6 as rs2 -> exactly 1 cycle stall_if=1/bubble_s2=1, then forward_B=10; stall_cnt=1.
REQ-033 Sequence lw x7 then beq uses x7 -> 2 stall cycles, then forward_C=10; addi x7 then beq -> 1 stall, then forward_C=01.
REQ-034 Sequence add x0 then add reads x0 -> all selects 00, no stall.
REQ-035 Taken beq with no hazard -> flush_s1=1 for one cycle; taken beq during its stall cycle -> flush_s1=0 until the stall clears.
REQ-036 rst_n=0 asserted during the second load->branch stall cycle -> next cycle all outputs 0, stall_cnt=0.
